// File: rtl/lzc_norm_pkg.sv
// Shared types and constants for the LZC normaliser/arbiter slice.
package lzc_norm_pkg;

  localparam int unsigned LZC_W = 16;
  localparam int unsigned SHW   = 5;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_e;

  localparam logic [SHW-1:0] ZERO_SHIFT = 5'd16;

  typedef struct packed {
    logic [LZC_W-1:0] op;
    req_id_e          id;
  } s1_t;

  typedef struct packed {
    logic [LZC_W-1:0] mant;
    logic [SHW-1:0]   shift;
    logic             zero;
    req_id_e          id;
  } s2_t;

endpackage

// File: rtl/lzc16.sv
// 16-bit leading-zero counter; count is meaningless for an all-zero input.
module lzc16 (
  input  logic [15:0] x,
  output logic [3:0]  c
);

  // Scan upward so the highest set bit is the last one to write c.
  always_comb begin
    c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (x[i]) c = 4'(15 - i);
    end
  end

endmodule

// File: rtl/lzc_norm_arbiter.sv
// Two-requester round-robin front end sharing one lzc16, producing normalised
// mantissas through a two-stage valid/ready pipeline.
module lzc_norm_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [SHW-1:0]   out_shift,
  output logic             out_zero,
  output logic             out_id
);
  import lzc_norm_pkg::*;

  if (WIDTH != LZC_W) begin : g_bad_width
    $error("lzc_norm_arbiter: WIDTH must be 16 to match lzc16");
  end
  if (SHW < 5) begin : g_bad_shw
    $error("lzc_norm_arbiter: SHW must be at least 5 to represent 16");
  end

  logic    s1_valid, s2_valid;
  s1_t     s1_q, req;
  s2_t     s2_q, s2_d;
  req_id_e rr_fav;
  logic    s1_en, s2_en;
  logic    grant_a, grant_b;
  logic [3:0] lz_c;

  assign s2_en = ~s2_valid | out_ready;
  assign s1_en = ~s1_valid | s2_en;

  assign grant_a = a_valid & (~b_valid | (rr_fav == ID_A));
  assign grant_b = b_valid & (~a_valid | (rr_fav == ID_B));

  assign a_ready = grant_a & s1_en & ~reset;
  assign b_ready = grant_b & s1_en & ~reset;

  always_comb begin
    req.op = grant_b ? b_data : a_data;
    req.id = grant_b ? ID_B : ID_A;
  end

  lzc16 u_lzc (
    .x (s1_q.op),
    .c (lz_c)
  );

  // lzc16 gives no zero indication, so the all-zero operand is forced here.
  always_comb begin
    s2_d.id = s1_q.id;
    if (s1_q.op == '0) begin
      s2_d.zero  = 1'b1;
      s2_d.shift = ZERO_SHIFT;
      s2_d.mant  = '0;
    end else begin
      s2_d.zero  = 1'b0;
      s2_d.shift = {1'b0, lz_c};
      s2_d.mant  = s1_q.op << lz_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      rr_fav   <= ID_A;
    end else begin
      if (s1_en) begin
        s1_valid <= grant_a | grant_b;
        s1_q     <= req;
      end
      if (a_ready | b_ready) rr_fav <= grant_a ? ID_B : ID_A;
      if (s2_en) begin
        s2_valid <= s1_valid;
        s2_q     <= s2_d;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_mant  = s2_q.mant;
  assign out_shift = SHW'(s2_q.shift);
  assign out_zero  = s2_q.zero;
  assign out_id    = s2_q.id;

endmodule
